// File: rtl/vx_mem_burst_master.sv
// vx_mem_burst_master
// Initiator side of the memory request/response interface. Takes one full
// cache line request, issues a single address request, then either streams
// BEATS write beats out or gathers BEATS read beats into a line and returns
// it. Only one transaction is ever outstanding.
// Optional build macro: VX_MEM_BURST_TIMEOUT_EN enables a stall watchdog that
// abandons a transaction after 1023 cycles without handshake progress.
module vx_mem_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 8,
  localparam int LINE_WIDTH = BEAT_WIDTH * BEATS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_req_valid,
  output logic                  line_req_ready,
  input  logic                  line_req_rw,
  input  logic [ADDR_WIDTH-1:0] line_req_addr,
  input  logic [TAG_WIDTH-1:0]  line_req_tag,
  input  logic [LINE_WIDTH-1:0] line_req_data,
  output logic                  line_rsp_valid,
  input  logic                  line_rsp_ready,
  output logic [LINE_WIDTH-1:0] line_rsp_data,
  output logic [TAG_WIDTH-1:0]  line_rsp_tag,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [TAG_WIDTH-1:0]  mem_req_tag,
  output logic                  mem_req_data_valid,
  input  logic                  mem_req_data_ready,
  output logic [BEAT_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_valid,
  input  logic [BEAT_WIDTH-1:0] mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]  mem_rsp_tag,
  output logic                  err
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
  localparam logic [2:0] S_RSP   = 3'd4;

  logic [2:0]                           r_state;
  logic                                 r_rw;
  logic [ADDR_WIDTH-1:0]                r_addr;
  logic [TAG_WIDTH-1:0]                 r_tag;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]     r_line;
  logic [CW-1:0]                        r_cnt;
  logic                                 r_err;
  logic                                 w_last;
  logic [CW-1:0]                        w_cnt_next;
`ifdef VX_MEM_BURST_TIMEOUT_EN
  logic [15:0]                          r_wdog;
  logic                                 w_busy;
  logic                                 w_progress;
`endif

  // Beat counter step with explicit wrap so non-power-of-two BEATS works.
  always_comb begin
    w_last     = (r_cnt == LAST_BEAT);
    w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
  end

`ifdef VX_MEM_BURST_TIMEOUT_EN
  // Watchdog qualifiers: which states can stall, and what counts as progress.
  always_comb begin
    w_busy     = (r_state == S_REQ) || (r_state == S_WDATA) || (r_state == S_RDATA);
    w_progress = ((r_state == S_REQ)   && mem_req_ready) ||
                 ((r_state == S_WDATA) && mem_req_data_ready) ||
                 ((r_state == S_RDATA) && mem_rsp_valid);
  end
`endif

  // Transaction sequencer: latch request, issue address, move beats, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_tag   <= '0;
      r_line  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
`ifdef VX_MEM_BURST_TIMEOUT_EN
      r_wdog  <= '0;
`endif
    end else begin
      // Read beats cannot be stalled, so any beat arriving outside RDATA is lost.
      if (mem_rsp_valid && (r_state != S_RDATA)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (line_req_valid) begin
            r_rw    <= line_req_rw;
            r_addr  <= line_req_addr;
            r_tag   <= line_req_tag;
            r_line  <= line_req_data;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= '0;
          if (mem_req_ready) begin
            r_state <= r_rw ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: begin
          if (mem_req_data_ready) begin
            r_cnt <= w_cnt_next;
            if (w_last) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_RDATA: begin
          if (mem_rsp_valid) begin
            r_line[r_cnt] <= mem_rsp_data;
            if (mem_rsp_tag != r_tag) begin
              r_err <= 1'b1;
            end
            r_cnt <= w_cnt_next;
            if (w_last) begin
              r_state <= S_RSP;
            end
          end
        end
        S_RSP: begin
          if (line_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef VX_MEM_BURST_TIMEOUT_EN
      // Placed after the case so an expiry overrides the normal next state.
      if (!w_busy || w_progress) begin
        r_wdog <= '0;
      end else if (r_wdog == 16'd1023) begin
        r_err   <= 1'b1;
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_wdog  <= '0;
      end else begin
        r_wdog <= r_wdog + 16'd1;
      end
`endif
    end
  end

  // Handshake outputs are pure state decodes; payloads come from latched regs.
  always_comb begin
    line_req_ready     = (r_state == S_IDLE);
    mem_req_valid      = (r_state == S_REQ);
    mem_req_data_valid = (r_state == S_WDATA);
    line_rsp_valid     = (r_state == S_RSP);
    mem_req_rw         = r_rw;
    mem_req_addr       = r_addr;
    mem_req_tag        = r_tag;
    mem_req_data       = r_line[r_cnt];
    line_rsp_data      = r_line;
    line_rsp_tag       = r_tag;
    err                = r_err;
  end

endmodule

// File: tb/tb_vx_mem_burst_master.sv
// Testbench for vx_mem_burst_master: plays the memory responder and the line
// requester, keeps a line-addressed memory model, and checks every transaction.
module tb_vx_mem_burst_master;

  localparam int AW = 32;
  localparam int TW = 8;
  localparam int BW = 64;
  localparam int NB = 8;
  localparam int LW = BW * NB;

  logic          clk = 1'b0;
  logic          reset;
  logic          line_req_valid, line_req_ready, line_req_rw;
  logic [AW-1:0] line_req_addr;
  logic [TW-1:0] line_req_tag;
  logic [LW-1:0] line_req_data;
  logic          line_rsp_valid, line_rsp_ready;
  logic [LW-1:0] line_rsp_data;
  logic [TW-1:0] line_rsp_tag;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [BW-1:0] mem_req_data;
  logic          mem_rsp_valid;
  logic [BW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          err;

  always #5 clk = ~clk;

  vx_mem_burst_master #(
    .ADDR_WIDTH(AW),
    .TAG_WIDTH (TW),
    .BEAT_WIDTH(BW),
    .BEATS     (NB)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .line_req_valid    (line_req_valid),
    .line_req_ready    (line_req_ready),
    .line_req_rw       (line_req_rw),
    .line_req_addr     (line_req_addr),
    .line_req_tag      (line_req_tag),
    .line_req_data     (line_req_data),
    .line_rsp_valid    (line_rsp_valid),
    .line_rsp_ready    (line_rsp_ready),
    .line_rsp_data     (line_rsp_data),
    .line_rsp_tag      (line_rsp_tag),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_rw        (mem_req_rw),
    .mem_req_addr      (mem_req_addr),
    .mem_req_tag       (mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data      (mem_req_data),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .mem_rsp_tag       (mem_rsp_tag),
    .err               (err)
  );

  int errors = 0;
  int checks = 0;

  // Reference memory, one entry per line address.
  logic [LW-1:0] model_mem [logic [AW-1:0]];

  // What the requester/responder observed during the last transaction.
  int            ob_req_cyc, ob_nbeats, ob_rsp_cyc, ob_rsp_count, ob_done_cyc;
  logic          ob_rw, ob_rsp_stable, ob_timeout, ob_ready_at_start;
  logic [AW-1:0] ob_addr;
  logic [TW-1:0] ob_tag, ob_rsp_tag;
  logic [BW-1:0] ob_beat [NB];
  int            ob_beat_cyc [NB];
  logic [LW-1:0] ob_rsp_data;

  function automatic logic [BW-1:0] beat_of(input logic [LW-1:0] l, input int i);
    logic [LW-1:0] t;
    t = l >> (i * BW);
    return t[BW-1:0];
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LW-1:0] get_line(input logic [AW-1:0] a);
    if (!model_mem.exists(a)) model_mem[a] = rand_line();
    return model_mem[a];
  endfunction

  function automatic logic roll(input int stall_pct);
    return ($urandom_range(99) >= stall_pct);
  endfunction

  task automatic idle_inputs();
    line_req_valid     = 1'b0;
    line_req_rw        = 1'b0;
    line_req_addr      = '0;
    line_req_tag       = '0;
    line_req_data      = '0;
    line_rsp_ready     = 1'b0;
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    mem_rsp_valid      = 1'b0;
    mem_rsp_data       = '0;
    mem_rsp_tag        = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drives one line request (cycle 0) and acts as responder until the master
  // is ready for the next request. Cycle numbers are relative to cycle 0.
  task automatic drive_txn(input logic rw, input logic [AW-1:0] addr,
                           input logic [TW-1:0] tag, input logic [LW-1:0] wline,
                           input int stall_pct, input int rsp_delay,
                           input int bad_beat, input logic [TW-1:0] bad_tag,
                           input logic hold_req);
    int cyc, sent, held;
    logic req_hs;
    logic [LW-1:0] rline;
    rline = rw ? '0 : get_line(addr);
    ob_req_cyc = -1; ob_nbeats = 0; ob_rsp_cyc = -1; ob_rsp_count = 0;
    ob_done_cyc = -1; ob_rsp_stable = 1'b1; ob_timeout = 1'b0;
    ob_rw = 1'bx; ob_addr = 'x; ob_tag = 'x; ob_rsp_data = 'x; ob_rsp_tag = 'x;
    ob_ready_at_start = line_req_ready;
    line_req_valid = 1'b1;
    line_req_rw    = rw;
    line_req_addr  = addr;
    line_req_tag   = tag;
    line_req_data  = wline;
    req_hs = 1'b0; sent = 0; held = 0;
    @(posedge clk); #1;
    cyc = 1;
    if (hold_req) begin
      line_req_rw   = ~rw;
      line_req_addr = ~addr;
      line_req_tag  = ~tag;
      line_req_data = ~wline;
    end else begin
      line_req_valid = 1'b0;
    end
    while (1) begin
      if (cyc > 300) begin
        ob_timeout = 1'b1;
        break;
      end
      if (line_req_ready) begin
        ob_done_cyc = cyc;
        break;
      end
      mem_rsp_valid = 1'b0;
      if (!rw && req_hs && sent < NB && roll(stall_pct)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = beat_of(rline, sent);
        mem_rsp_tag   = (sent == bad_beat) ? bad_tag : tag;
        sent++;
      end
      mem_req_ready = roll(stall_pct);
      if (mem_req_valid && mem_req_ready && !req_hs) begin
        req_hs     = 1'b1;
        ob_req_cyc = cyc;
        ob_rw      = mem_req_rw;
        ob_addr    = mem_req_addr;
        ob_tag     = mem_req_tag;
      end
      mem_req_data_ready = roll(stall_pct);
      if (mem_req_data_valid && mem_req_data_ready) begin
        if (ob_nbeats < NB) begin
          ob_beat[ob_nbeats]     = mem_req_data;
          ob_beat_cyc[ob_nbeats] = cyc;
        end
        ob_nbeats++;
      end
      line_rsp_ready = 1'b0;
      if (line_rsp_valid) begin
        if (ob_rsp_cyc < 0) begin
          ob_rsp_cyc  = cyc;
          ob_rsp_data = line_rsp_data;
          ob_rsp_tag  = line_rsp_tag;
        end else if (line_rsp_data !== ob_rsp_data || line_rsp_tag !== ob_rsp_tag) begin
          ob_rsp_stable = 1'b0;
        end
        if (held >= rsp_delay) begin
          line_rsp_ready = 1'b1;
          ob_rsp_count++;
        end
        held++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (line_req_ready !== 1'b1) begin errors++; $display("FAIL reset_line_req_ready: got %b expected 1", line_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (mem_req_data_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_data_valid: got %b expected 0", mem_req_data_valid); end
    checks++; if (line_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_line_rsp_valid: got %b expected 0", line_rsp_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (line_rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", line_rsp_data); end
    checks++; if (line_rsp_tag !== '0 || mem_req_addr !== '0) begin errors++; $display("FAIL reset_tag_addr: got tag %h addr %h expected 0 0", line_rsp_tag, mem_req_addr); end
  endtask

  task automatic test_zero_wait_write();
    logic [LW-1:0] wl;
    logic [BW-1:0] exp;
    for (int i = 0; i < NB; i++) wl[i*BW +: BW] = 64'h1111_0000_0000_0000 + 64'(i);
    drive_txn(1'b1, 32'h10, 8'h3, wl, 0, 0, -1, 8'h0, 1'b0);
    model_mem[32'h10] = wl;
    checks++; if (ob_ready_at_start !== 1'b1) begin errors++; $display("FAIL wr_ready_start: got %b expected 1", ob_ready_at_start); end
    checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL wr_timeout: got %b expected 0", ob_timeout); end
    checks++; if (ob_req_cyc != 1) begin errors++; $display("FAIL wr_req_cycle: got %0d expected 1", ob_req_cyc); end
    checks++; if (ob_rw !== 1'b1 || ob_addr !== 32'h10 || ob_tag !== 8'h3) begin errors++; $display("FAIL wr_req_fields: got rw %b addr %h tag %h expected 1 10 03", ob_rw, ob_addr, ob_tag); end
    checks++; if (ob_nbeats != NB) begin errors++; $display("FAIL wr_nbeats: got %0d expected %0d", ob_nbeats, NB); end
    for (int i = 0; i < NB && i < ob_nbeats; i++) begin
      exp = 64'h1111_0000_0000_0000 + 64'(i);
      checks++;
      if (ob_beat[i] !== exp || ob_beat_cyc[i] != 2 + i) begin
        errors++;
        $display("FAIL wr_beat%0d: got %h at cycle %0d expected %h at cycle %0d", i, ob_beat[i], ob_beat_cyc[i], exp, 2 + i);
      end
    end
    checks++; if (ob_done_cyc != 10) begin errors++; $display("FAIL wr_ready_return: got cycle %0d expected 10", ob_done_cyc); end
    checks++; if (ob_rsp_count != 0) begin errors++; $display("FAIL wr_no_line_rsp: got %0d expected 0", ob_rsp_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", err); end
  endtask

  task automatic test_zero_wait_read();
    logic [LW-1:0] exp;
    exp = get_line(32'h10);
    drive_txn(1'b0, 32'h10, 8'h5, '0, 0, 0, -1, 8'h0, 1'b0);
    checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL rd_timeout: got %b expected 0", ob_timeout); end
    checks++; if (ob_req_cyc != 1 || ob_rw !== 1'b0 || ob_addr !== 32'h10) begin errors++; $display("FAIL rd_req: got cycle %0d rw %b addr %h expected 1 0 10", ob_req_cyc, ob_rw, ob_addr); end
    checks++; if (ob_rsp_cyc != 10) begin errors++; $display("FAIL rd_rsp_cycle: got %0d expected 10", ob_rsp_cyc); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (beat_of(ob_rsp_data, i) !== beat_of(exp, i)) begin
        errors++;
        $display("FAIL rd_beat%0d: got %h expected %h", i, beat_of(ob_rsp_data, i), beat_of(exp, i));
      end
    end
    checks++; if (ob_rsp_tag !== 8'h5) begin errors++; $display("FAIL rd_tag: got %h expected 05", ob_rsp_tag); end
    checks++; if (ob_rsp_count != 1) begin errors++; $display("FAIL rd_rsp_count: got %0d expected 1", ob_rsp_count); end
    checks++; if (ob_done_cyc != 11) begin errors++; $display("FAIL rd_ready_return: got cycle %0d expected 11", ob_done_cyc); end
    checks++; if (ob_nbeats != 0 || err !== 1'b0) begin errors++; $display("FAIL rd_clean: got wbeats %0d err %b expected 0 0", ob_nbeats, err); end
  endtask

  task automatic test_rsp_backpressure();
    logic [LW-1:0] exp;
    exp = get_line(32'h10);
    // line_req_valid stays high with different fields while busy; must be ignored.
    drive_txn(1'b0, 32'h10, 8'h5, '0, 0, 5, -1, 8'h0, 1'b1);
    checks++; if (ob_rsp_cyc != 10) begin errors++; $display("FAIL bp_rsp_cycle: got %0d expected 10", ob_rsp_cyc); end
    checks++; if (ob_rsp_stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b expected 1", ob_rsp_stable); end
    checks++; if (ob_rsp_count != 1) begin errors++; $display("FAIL bp_rsp_count: got %0d expected 1", ob_rsp_count); end
    checks++; if (ob_done_cyc != 16) begin errors++; $display("FAIL bp_ready_return: got cycle %0d expected 16", ob_done_cyc); end
    checks++; if (ob_rsp_data !== exp || ob_rsp_tag !== 8'h5) begin errors++; $display("FAIL bp_data_tag: got tag %h expected 05 (data equal=%b)", ob_rsp_tag, ob_rsp_data === exp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bp_err: got %b expected 0", err); end
  endtask

  task automatic test_bad_tag();
    logic [LW-1:0] exp;
    exp = get_line(32'h10);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL badtag_pre_err: got %b expected 0", err); end
    drive_txn(1'b0, 32'h10, 8'h5, '0, 0, 0, 3, 8'h9, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badtag_err: got %b expected 1", err); end
    checks++; if (ob_rsp_count != 1 || ob_rsp_data !== exp) begin errors++; $display("FAIL badtag_line: got count %0d beat3 %h expected 1 %h", ob_rsp_count, beat_of(ob_rsp_data, 3), beat_of(exp, 3)); end
    exp = rand_line();
    drive_txn(1'b1, 32'h20, 8'h7, exp, 0, 0, -1, 8'h0, 1'b0);
    model_mem[32'h20] = exp;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badtag_sticky: got %b expected 1", err); end
  endtask

  task automatic test_idle_rsp();
    apply_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_rsp_pre_err: got %b expected 0", err); end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {$urandom, $urandom};
    mem_rsp_tag   = 8'h5;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL idle_rsp_err: got %b expected 1", err); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (line_rsp_valid !== 1'b0 || line_req_ready !== 1'b1 || err !== 1'b1) begin
        errors++;
        $display("FAIL idle_rsp_quiet%0d: got rsp_valid %b ready %b err %b expected 0 1 1", i, line_rsp_valid, line_req_ready, err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [LW-1:0] wl, exp;
    wl = rand_line();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL midrst_pre_err: got %b expected 1", err); end
    line_req_valid = 1'b1; line_req_rw = 1'b1; line_req_addr = 32'h30;
    line_req_tag = 8'h4; line_req_data = wl;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    @(posedge clk); #1;
    line_req_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      @(posedge clk); #1;
    end
    checks++; if (mem_req_data_valid !== 1'b1 || mem_req_data !== beat_of(wl, 4)) begin errors++; $display("FAIL midrst_beat4: got valid %b data %h expected 1 %h", mem_req_data_valid, mem_req_data, beat_of(wl, 4)); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
    checks++; if (line_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got ready %b expected 1", line_req_ready); end
    checks++; if (mem_req_valid !== 1'b0 || mem_req_data_valid !== 1'b0 || line_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valids: got %b%b%b expected 000", mem_req_valid, mem_req_data_valid, line_rsp_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", err); end
    idle_inputs();
    exp = get_line(32'h10);
    drive_txn(1'b0, 32'h10, 8'h6, '0, 0, 0, -1, 8'h0, 1'b0);
    checks++; if (ob_rsp_data !== exp || ob_done_cyc != 11 || ob_rsp_tag !== 8'h6) begin errors++; $display("FAIL midrst_recover: got done %0d tag %h expected 11 06 (data equal=%b)", ob_done_cyc, ob_rsp_tag, ob_rsp_data === exp); end
  endtask

  task automatic test_random();
    logic rw;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic [LW-1:0] wl, exp;
    apply_reset();
    for (int n = 0; n < 24; n++) begin
      rw   = 1'($urandom_range(1));
      addr = 32'h40 + 32'($urandom_range(3));
      tag  = 8'($urandom);
      wl   = rand_line();
      exp  = rw ? wl : get_line(addr);
      drive_txn(rw, addr, tag, wl, 30, $urandom_range(3), -1, 8'h0, 1'b0);
      checks++;
      if (ob_timeout !== 1'b0 || ob_rw !== rw || ob_addr !== addr || ob_tag !== tag) begin
        errors++;
        $display("FAIL rand%0d_req: got to %b rw %b addr %h tag %h expected 0 %b %h %h", n, ob_timeout, ob_rw, ob_addr, ob_tag, rw, addr, tag);
      end
      if (rw) begin
        model_mem[addr] = wl;
        checks++;
        if (ob_nbeats != NB || ob_rsp_count != 0) begin
          errors++;
          $display("FAIL rand%0d_wcount: got beats %0d rsp %0d expected %0d 0", n, ob_nbeats, ob_rsp_count, NB);
        end
        for (int i = 0; i < NB && i < ob_nbeats; i++) begin
          checks++;
          if (ob_beat[i] !== beat_of(exp, i)) begin
            errors++;
            $display("FAIL rand%0d_wbeat%0d: got %h expected %h", n, i, ob_beat[i], beat_of(exp, i));
          end
        end
      end else begin
        checks++;
        if (ob_rsp_count != 1 || ob_rsp_data !== exp || ob_rsp_tag !== tag) begin
          errors++;
          $display("FAIL rand%0d_read: got count %0d tag %h expected 1 %h (data equal=%b)", n, ob_rsp_count, ob_rsp_tag, tag, ob_rsp_data === exp);
        end
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b expected 0", err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_zero_wait_write();
    test_zero_wait_read();
    test_rsp_backpressure();
    test_bad_tag();
    test_idle_rsp();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
